// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states, opcode classes, opcode map,
// ALU operations and PC source selects.
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH      = 3'd0,
      DECODE     = 3'd1,
      EXECUTE    = 3'd2,
      MEM_ACCESS = 3'd3,
      WRITE_BACK = 3'd4,
      BRANCH     = 3'd5,
      HALT       = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU = 3'd0,
      CLS_LD  = 3'd1,
      CLS_ST  = 3'd2,
      CLS_J   = 3'd3,
      CLS_BR  = 3'd4,
      CLS_HLT = 3'd5,
      CLS_ILL = 3'd6
   } op_class_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_LD  = 4'b0101;
   localparam logic [3:0] OP_ST  = 4'b0110;
   localparam logic [3:0] OP_J   = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BNE = 4'b1001;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_CMP = 3'b110;

   localparam logic [1:0] PC_SRC_INC = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode classifier and ALU-operation lookup; zero latency, no handshake.
// Any set bit above [3:0] makes the opcode illegal.
module ctrl_op_decode
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ALUCTL_W = 3
) (
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class,
   output logic [ALUCTL_W-1:0] alu_op
);

   logic [3:0] op_lo;
   logic       hi_clear;

   assign op_lo    = opcode[3:0];
   assign hi_clear = ((opcode >> 4) == '0);

   always_comb begin
      op_class = CLS_ILL;
      alu_op   = '0;
      if (hi_clear) begin
         case (op_lo)
            OP_ADD: begin op_class = CLS_ALU; alu_op = ALUCTL_W'(ALU_ADD); end
            OP_SUB: begin op_class = CLS_ALU; alu_op = ALUCTL_W'(ALU_SUB); end
            OP_AND: begin op_class = CLS_ALU; alu_op = ALUCTL_W'(ALU_AND); end
            OP_OR:  begin op_class = CLS_ALU; alu_op = ALUCTL_W'(ALU_OR);  end
            OP_XOR: begin op_class = CLS_ALU; alu_op = ALUCTL_W'(ALU_XOR); end
            OP_LD:  op_class = CLS_LD;
            OP_ST:  op_class = CLS_ST;
            OP_J:   op_class = CLS_J;
            OP_BEQ: op_class = CLS_BR;
            OP_BNE: op_class = CLS_BR;
            OP_HLT: op_class = CLS_HLT;
            default: op_class = CLS_ILL;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM; 2-5 cycles per instruction, stalls in FETCH/MEM_ACCESS while mem_ready=0.
// Retired-instruction counter is built only when CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ALUCTL_W = 3,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic                result_src,
   output logic                alu_src,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic                illegal_op,
   output logic                halted,
   output logic [CNT_W-1:0]    retired_cnt
);

   state_t              state;
   state_t              next_state;
   logic [OPCODE_W-1:0] op_q;
   logic [OPCODE_W-1:0] dec_in;
   op_class_t           op_class;
   logic [ALUCTL_W-1:0] alu_op;
   logic                is_beq;
   logic                taken;

   // The opcode port is only looked at in DECODE; every later state classifies the latched op_q.
   assign dec_in = (state == DECODE) ? opcode : op_q;
   assign is_beq = (op_q == OPCODE_W'(OP_BEQ));
   assign taken  = is_beq ? zero : !zero;

   ctrl_op_decode #(
      .OPCODE_W (OPCODE_W),
      .ALUCTL_W (ALUCTL_W)
   ) u_dec (
      .opcode   (dec_in),
      .op_class (op_class),
      .alu_op   (alu_op)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         op_q  <= '0;
      end else begin
         state <= next_state;
         if (state == DECODE) op_q <= opcode;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH:      if (mem_ready) next_state = DECODE;
         DECODE: begin
            case (op_class)
               CLS_ALU, CLS_LD, CLS_ST: next_state = EXECUTE;
               CLS_BR:                  next_state = BRANCH;
               CLS_HLT:                 next_state = HALT;
               default:                 next_state = FETCH;
            endcase
         end
         EXECUTE:    next_state = (op_class == CLS_ALU) ? WRITE_BACK : MEM_ACCESS;
         MEM_ACCESS: if (mem_ready) next_state = (op_class == CLS_LD) ? WRITE_BACK : FETCH;
         WRITE_BACK: next_state = FETCH;
         BRANCH:     next_state = FETCH;
         HALT:       next_state = HALT;
         default:    next_state = FETCH;
      endcase
   end

   // Reset gates every control line so nothing reaches the datapath while it is held.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SRC_INC;
      reg_write   = 1'b0;
      result_src  = 1'b0;
      alu_src     = 1'b0;
      alu_control = '0;
      illegal_op  = 1'b0;
      halted      = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_INC;
               end
            end
            DECODE: begin
               if (op_class == CLS_J) begin
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_JMP;
               end
               illegal_op = (op_class == CLS_ILL);
            end
            EXECUTE: begin
               if (op_class == CLS_ALU) begin
                  alu_control = alu_op;
               end else begin
                  alu_control = ALUCTL_W'(ALU_ADD);
                  alu_src     = 1'b1;
               end
            end
            MEM_ACCESS: begin
               iord        = 1'b1;
               alu_control = ALUCTL_W'(ALU_ADD);
               alu_src     = 1'b1;
               mem_read    = (op_class == CLS_LD);
               mem_write   = (op_class == CLS_ST);
            end
            WRITE_BACK: begin
               reg_write  = 1'b1;
               result_src = (op_class == CLS_LD);
            end
            BRANCH: begin
               alu_control = ALUCTL_W'(ALU_CMP);
               pc_write    = taken;
               pc_src      = PC_SRC_BR;
            end
            HALT:    halted = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic             retire;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      retire = 1'b0;
      case (state)
         WRITE_BACK, BRANCH: retire = 1'b1;
         MEM_ACCESS:         retire = mem_ready && (op_class == CLS_ST);
         DECODE:             retire = (op_class == CLS_J) || (op_class == CLS_HLT);
         default:            retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt_q <= '0;
      else if (retire) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign retired_cnt = cnt_q;
`else
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed per-cycle vector table for mc_ctrl_fsm plus a hand-written asynchronous-reset sequence.
module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        mem_read, mem_write, iord, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic        reg_write, result_src, alu_src;
   logic [2:0]  alu_control;
   logic        illegal_op, halted;
   logic [31:0] retired_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .iord        (iord),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src     (alu_src),
      .alu_control (alu_control),
      .illegal_op  (illegal_op),
      .halted      (halted),
      .retired_cnt (retired_cnt)
   );

   // Control word: {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write,
   //                result_src, alu_src, alu_control, illegal_op, halted, 1'b0}
   logic [15:0] act;
   assign act = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write,
                 result_src, alu_src, alu_control, illegal_op, halted, 1'b0};

   function automatic logic [15:0] cw(bit mr, bit mw, bit io, bit irw, bit pcw, bit [1:0] pcs,
                                      bit rw, bit rs, bit as, bit [2:0] alu, bit ill, bit h);
      return {mr, mw, io, irw, pcw, pcs, rw, rs, as, alu, ill, h, 1'b0};
   endfunction

   typedef struct {
      logic        rst;
      logic [3:0]  op;
      logic        z;
      logic        rdy;
      logic [15:0] word;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   logic [15:0] W_NONE, F_GO, F_WAIT, EX_MEM, MA_LD, MA_ST, WB_ALU, WB_LD, DEC_J, DEC_ILL, HLTW;

   task automatic add(input logic rst, input logic [3:0] op, input logic z, input logic rdy,
                      input logic [15:0] word, input logic [31:0] cnt);
      vec_t v;
      v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.word = word; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef CTRL_PERF_CNT_EN
      return c;
`else
      return (c & 32'h0);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want, input int idx);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
      end
   endtask

   initial begin
      W_NONE  = 16'h0;
      F_GO    = cw(1,0,0,1,1,2'b00,0,0,0,3'b000,0,0);
      F_WAIT  = cw(1,0,0,0,0,2'b00,0,0,0,3'b000,0,0);
      EX_MEM  = cw(0,0,0,0,0,2'b00,0,0,1,3'b001,0,0);
      MA_LD   = cw(1,0,1,0,0,2'b00,0,0,1,3'b001,0,0);
      MA_ST   = cw(0,1,1,0,0,2'b00,0,0,1,3'b001,0,0);
      WB_ALU  = cw(0,0,0,0,0,2'b00,1,0,0,3'b000,0,0);
      WB_LD   = cw(0,0,0,0,0,2'b00,1,1,0,3'b000,0,0);
      DEC_J   = cw(0,0,0,0,1,2'b10,0,0,0,3'b000,0,0);
      DEC_ILL = cw(0,0,0,0,0,2'b00,0,0,0,3'b000,1,0);
      HLTW    = cw(0,0,0,0,0,2'b00,0,0,0,3'b000,0,1);

      //   rst op    z  rdy  expected word                               cnt
      add(1, 4'h0, 0, 1, W_NONE, 0);                                   // held in reset
      add(0, 4'h0, 0, 1, F_GO, 0);                                     // ADD
      add(0, 4'h0, 0, 0, W_NONE, 0);                                   // DECODE ignores mem_ready
      add(0, 4'hF, 0, 1, cw(0,0,0,0,0,0,0,0,0,3'b001,0,0), 0);         // EXECUTE uses op_q
      add(0, 4'hF, 0, 1, WB_ALU, 0);
      add(0, 4'h0, 0, 0, F_WAIT, 1);                                   // fetch stall
      add(0, 4'h0, 0, 1, F_GO, 1);
      add(0, 4'h5, 0, 1, W_NONE, 1);                                   // LD
      add(0, 4'h0, 0, 1, EX_MEM, 1);
      add(0, 4'h6, 0, 0, MA_LD, 1);
      add(0, 4'h6, 0, 0, MA_LD, 1);
      add(0, 4'h6, 0, 1, MA_LD, 1);
      add(0, 4'h0, 0, 0, WB_LD, 1);
      add(0, 4'h0, 0, 1, F_GO, 2);
      add(0, 4'h8, 1, 1, W_NONE, 2);                                   // BEQ, zero=1
      add(0, 4'h0, 1, 1, cw(0,0,0,0,1,2'b01,0,0,0,3'b110,0,0), 2);
      add(0, 4'h0, 0, 1, F_GO, 3);
      add(0, 4'h9, 1, 1, W_NONE, 3);                                   // BNE, zero=1
      add(0, 4'h8, 1, 1, cw(0,0,0,0,0,2'b01,0,0,0,3'b110,0,0), 3);
      add(0, 4'h0, 0, 1, F_GO, 4);
      add(0, 4'h9, 0, 1, W_NONE, 4);                                   // BNE, zero=0
      add(0, 4'h8, 0, 1, cw(0,0,0,0,1,2'b01,0,0,0,3'b110,0,0), 4);
      add(0, 4'h0, 0, 1, F_GO, 5);
      add(0, 4'hA, 0, 1, DEC_ILL, 5);                                  // illegal
      add(0, 4'h0, 0, 1, F_GO, 5);
      add(0, 4'h7, 0, 1, DEC_J, 5);                                    // J
      add(0, 4'h0, 0, 1, F_GO, 6);
      add(0, 4'h3, 0, 1, W_NONE, 6);                                   // OR
      add(0, 4'h0, 0, 1, cw(0,0,0,0,0,0,0,0,0,3'b100,0,0), 6);
      add(0, 4'h0, 0, 1, WB_ALU, 6);
      add(0, 4'h0, 0, 1, F_GO, 7);
      add(0, 4'h4, 0, 1, W_NONE, 7);                                   // XOR
      add(0, 4'h0, 0, 1, cw(0,0,0,0,0,0,0,0,0,3'b101,0,0), 7);
      add(0, 4'h0, 0, 1, WB_ALU, 7);
      add(0, 4'h0, 0, 1, F_GO, 8);
      add(0, 4'h6, 0, 1, W_NONE, 8);                                   // ST
      add(0, 4'h0, 0, 1, EX_MEM, 8);
      add(0, 4'h5, 0, 1, MA_ST, 8);
      add(0, 4'h0, 0, 1, F_GO, 9);
      add(0, 4'hF, 0, 1, W_NONE, 9);                                   // HLT
      for (int i = 0; i < 10; i++) add(0, 4'h0, 0, i[0], HLTW, 10);
      add(1, 4'h0, 0, 1, W_NONE, 0);                                   // reset leaves HALT
      add(0, 4'h0, 0, 1, F_GO, 0);
      add(0, 4'h6, 0, 1, W_NONE, 0);                                   // ST aborted by reset
      add(0, 4'h0, 0, 1, EX_MEM, 0);
      add(0, 4'h0, 0, 0, MA_ST, 0);
      add(1, 4'h0, 0, 1, W_NONE, 0);
      add(0, 4'h0, 0, 0, F_WAIT, 0);

      reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
         @(negedge clk);
         check("ctl", {16'h0, act}, {16'h0, vecs[i].word}, i);
         check("cnt", retired_cnt, exp_cnt(vecs[i].cnt), i);
      end

      // Reset raised between clock edges while an ST sits in MEM_ACCESS must clear mem_write at once.
      @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b1;                 // FETCH -> DECODE
      @(posedge clk); #1 opcode = 4'h6;                                  // DECODE
      @(posedge clk); #1 opcode = 4'h0;                                  // EXECUTE
      @(posedge clk); #1 mem_ready = 1'b0;                               // MEM_ACCESS, stalled
      #2;
      check("st_mem_write", {31'h0, mem_write}, 32'h1, 100);
      reset = 1'b1;
      #1;
      check("async_ctl", {16'h0, act}, 32'h0, 101);
      check("async_cnt", retired_cnt, 32'h0, 102);
      @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      check("post_rst", {16'h0, act}, {16'h0, F_WAIT}, 103);
      @(posedge clk); #1;
      check("fetch_hold", {16'h0, act}, {16'h0, F_WAIT}, 104);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the single-bus CPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake. It resolves BEQ/BNE in a dedicated branch state, halts on HLT and flags illegal opcodes. It drives the PC, IR, register file, ALU, address mux and data memory control lines.

## Interface
- OPCODE_W, 4: opcode width, minimum 4. Bits above [3:0] must be zero, otherwise the opcode is illegal.
- ALUCTL_W, 3: alu_control width, minimum 3.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-high.
- opcode, in, OPCODE_W: opcode field from the IR. Sampled in DECODE only.
- zero, in, 1: ALU zero flag. Sampled in BRANCH only.
- mem_ready, in, 1: memory completes the current access this cycle.
- mem_read, out, 1: memory read request.
- mem_write, out, 1: memory write request.
- iord, out, 1: memory address select. 0 = PC, 1 = ALU result.
- ir_write, out, 1: load IR.
- pc_write, out, 1: load PC.
- pc_src, out, 2: PC source. 00 = PC+1, 01 = branch target, 10 = jump target.
- reg_write, out, 1: register file write enable.
- result_src, out, 1: write-back source. 0 = ALU, 1 = memory data.
- alu_src, out, 1: ALU B operand. 0 = register, 1 = immediate.
- alu_control, out, ALUCTL_W: ALU operation.
- illegal_op, out, 1: one-cycle pulse on an unrecognised opcode.
- halted, out, 1: high while in HALT.
- retired_cnt, out, CNT_W: count of retired instructions.

## Operation
Opcode map:
- 0000 ADD, ALU op 001.
- 0001 SUB, ALU op 010.
- 0010 AND, ALU op 011.
- 0011 OR, ALU op 100.
- 0100 XOR, ALU op 101.
- 0101 LD.
- 0110 ST.
- 0111 J.
- 1000 BEQ.
- 1001 BNE.
- 1111 HLT.
- All other values are illegal.

In DECODE the opcode is latched into op_q. All later states use op_q and never read the opcode port.

States and transitions. All outputs are 0 unless listed.
- FETCH: mem_read=1, iord=0. While mem_ready=0, stay in FETCH. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: latch op_q, no control outputs.
  - ALU ops, LD and ST go to EXECUTE.
  - J: pc_write=1, pc_src=10, go to FETCH.
  - BEQ and BNE go to BRANCH.
  - HLT goes to HALT.
  - Illegal opcode: illegal_op=1, go to FETCH.
- EXECUTE: alu_control = op_q's ALU op. For LD and ST, alu_control=001 and alu_src=1. ALU ops go to WRITE_BACK; LD and ST go to MEM_ACCESS.
- MEM_ACCESS: iord=1, alu_control=001, alu_src=1. LD drives mem_read=1; ST drives mem_write=1. Hold in this state while mem_ready=0. When mem_ready=1, LD goes to WRITE_BACK and ST goes to FETCH.
- WRITE_BACK: reg_write=1, result_src=(op_q==LD), go to FETCH.
- BRANCH: alu_control=110 (compare), taken = BEQ ? zero : !zero. pc_write=taken, pc_src=01, go to FETCH.
- HALT: halted=1, no other outputs. Only reset leaves HALT.

Retirement. Counted on the last cycle of each instruction:
- WRITE_BACK.
- MEM_ACCESS for ST, on the cycle mem_ready=1.
- BRANCH.
- DECODE for J and HLT.
- Illegal opcodes do not retire.

## Timing
- Reset asserted: state=FETCH, op_q=0, retired_cnt=0. While reset is high, every output is forced to 0.
- First cycle after reset release: mem_read=1.
- Outputs are Moore-decoded from state. Exceptions: ir_write/pc_write in FETCH and the exit from MEM_ACCESS depend on mem_ready in the same cycle.
- Latency with mem_ready tied to 1:
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - J: 2 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with mem_ready=0 in FETCH or MEM_ACCESS adds one cycle and holds every output at its value.
- Reset mid-instruction aborts it, with no PC, register or memory write afterwards. The aborted instruction is not counted.
- mem_ready outside FETCH and MEM_ACCESS is ignored.
- retired_cnt wraps modulo 2^CNT_W.

## Configuration
- CTRL_PERF_CNT_EN defined: the retired_cnt counter is implemented as described in Operation.
- CTRL_PERF_CNT_EN undefined: the port remains and is tied to 0. No counter flops are built.

## Structure
- Package ctrl_pkg holds:
  - the state_t enum, 3 bits: FETCH, DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK, BRANCH, HALT;
  - opcode localparams;
  - ALU operation localparams;
  - pc_src localparams.
- Sub-module ctrl_op_decode: combinational. Maps the opcode to class (alu/ld/st/j/br/hlt/illegal) and to the ALU operation.

## Test plan
- Reset, release, mem_ready=1, ADD (0000) -> sequence FETCH, DECODE, EXECUTE, WRITE_BACK; reg_write=1 in cycle 4 with result_src=0; retired_cnt=1.
- LD (0101) with mem_ready low for 2 cycles in MEM_ACCESS -> mem_read and iord=1 held for 3 cycles; then WRITE_BACK with result_src=1; 7 cycles total.
- BEQ with zero=1 -> pc_write=1, pc_src=01 in BRANCH. BNE with zero=1 -> pc_write=0.
- Opcode 1010 -> illegal_op high for one cycle in DECODE; back in FETCH next cycle; retired_cnt unchanged.
- HLT (1111) -> halted=1 and stays high for 10 cycles with mem_read=0; reset returns the block to FETCH.
- Reset asserted in MEM_ACCESS of ST -> mem_write=0 immediately; FETCH after release; no write; retired_cnt=0. Repeat with CTRL_PERF_CNT_EN undefined -> retired_cnt always 0.
